tx_frame_byte_counter: RTL and testbench
========================================

// Module: tx_frame_byte_counter
// PURPOSE
//  Per-frame byte counter for the 10G TX engine, parametrised in datapath width and counter width.
//  Counts valid bytes beat-by-beat, including a partial last word.
//  At end of frame it latches the frame length and flags pad / oversize / saturation for the
//  framer and the statistics logic.
//  Sits between the TX data fetch path and the padding/FCS insertion stage.
// PARAMETERS
//  DATA_BYTES  8     bytes per datapath beat; power of two, >= 2
//  CNT_W       16    width of all byte-count outputs
//  MIN_FRAME   60    minimum frame length (bytes, excl. FCS); shorter frames need padding
//  MAX_FRAME   1514  maximum legal frame length (bytes, excl. FCS)
// PORTS
//  CLK        in   1      clock
//  RESET      in   1      asynchronous, active-high reset
//  CLR        in   1      synchronous clear; same effect as RESET
//  DATA_VALID in   1      beat qualifier; SOF, EOF and EOF_BYTES are sampled only when high
//  SOF        in   1      first beat of frame
//  EOF        in   1      last beat of frame
//  EOF_BYTES  in   EB_W   valid bytes in EOF beat; EB_W=$clog2(DATA_BYTES); 0 means DATA_BYTES
//  BYTE_COUNTER out CNT_W running count of the current frame
//  FRAME_LEN  out  CNT_W  length of the last completed frame
//  PAD_BYTES  out  CNT_W  MIN_FRAME-FRAME_LEN when PAD_REQ is high, else 0
//  FRAME_DONE out  1      one-cycle pulse when FRAME_LEN, PAD_* and OVERSIZE update
//  PAD_REQ    out  1      FRAME_LEN < MIN_FRAME
//  OVERSIZE   out  1      FRAME_LEN > MAX_FRAME, or the frame saturated
//  SATURATED  out  1      sticky: running count clamped during the current/last frame
//  PROTO_ERR  out  1      one-cycle pulse on a framing violation
// BEHAVIOUR
//  - Reset (RESET or CLR): state IDLE; every output = 0.
//  - FSM states IDLE, COUNT. All outputs are registered; each updates on the edge after the beat.
//  - inc = (EOF && EOF_BYTES!=0) ? EOF_BYTES : DATA_BYTES.
//  - IDLE, DATA_VALID&SOF&!EOF:
//      BYTE_COUNTER<=inc; SATURATED<=0; go to COUNT.
//  - IDLE, DATA_VALID&SOF&EOF (single-beat frame):
//      BYTE_COUNTER<=inc; complete the frame; stay in IDLE.
//  - IDLE, DATA_VALID&!SOF: beat ignored; PROTO_ERR pulses.
//  - COUNT, DATA_VALID&!SOF: BYTE_COUNTER<=sat(BYTE_COUNTER+inc).
//      If EOF is also high: complete the frame and go to IDLE.
//  - COUNT, DATA_VALID&SOF: PROTO_ERR pulses; the old frame is dropped (no FRAME_DONE).
//      The counter restarts as in IDLE, and the state follows the IDLE rules.
//  - DATA_VALID low: nothing changes; counts hold. Bubbles may occur anywhere in a frame.
//  - Complete frame: the final count feeds the following updates on the same edge:
//      FRAME_LEN, PAD_REQ, PAD_BYTES, OVERSIZE, and a 1-cycle FRAME_DONE pulse.
//      These hold until the next FRAME_DONE.
//      BYTE_COUNTER also holds the final value until the next SOF.
//  - Arithmetic: add at CNT_W+1 bits.
//      On carry, or any result above 2^CNT_W-1, clamp to all-ones and set SATURATED.
//      SATURATED clears only on SOF or reset.
//  - PAD_BYTES is computed at CNT_W width.
//      It is never negative: 0 whenever FRAME_LEN >= MIN_FRAME.
//  - RESET mid-frame: frame discarded; no FRAME_DONE; outputs 0 from the reset edge.
//      Counting resumes only on a new SOF.
// STRUCTURE
//  - Shared package/include tx_engine_pkg holds:
//      state encodings TXC_IDLE / TXC_COUNT;
//      the MIN_FRAME / MAX_FRAME default constants (shared with the padding stage).
//  - One sub-module: tx_sat_adder (CNT_W-bit saturating add with overflow flag).
//      The rest of the block is flat: FSM plus output registers.
// TESTING (DATA_BYTES=8, CNT_W=16 unless noted)
//  1. SOF, 6 full beats, EOF with EOF_BYTES=4 (8 beats total):
//     -> FRAME_LEN=60, PAD_REQ=0, PAD_BYTES=0, one FRAME_DONE.
//  2. SOF beat, then EOF with EOF_BYTES=2, bubbles between the beats:
//     -> FRAME_LEN=10, PAD_REQ=1, PAD_BYTES=50.
//  3. 190 full beats, EOF_BYTES=0 on the last:
//     -> FRAME_LEN=1520, OVERSIZE=1, PAD_REQ=0.
//  4. CNT_W=8, 40 full beats:
//     -> BYTE_COUNTER clamps at 255, SATURATED=1, OVERSIZE=1.
//     A following SOF clears SATURATED.
//  5. Single beat with SOF&EOF, EOF_BYTES=0 -> FRAME_LEN=8, PAD_BYTES=52.
//     Then a beat with no SOF in IDLE -> PROTO_ERR pulse, counts unchanged.
//  6. SOF in mid-frame -> PROTO_ERR, no FRAME_DONE for the old frame.
//     RESET mid-frame -> all outputs 0; the next frame counts from 0.

Source files
------------

// File: rtl/tx_engine_pkg.sv
// Shared TX engine definitions: counter FSM encodings and frame-length limits
// (the limits are also used by the padding stage).
package tx_engine_pkg;

    typedef enum logic [0:0] {
        TXC_IDLE  = 1'b0,
        TXC_COUNT = 1'b1
    } txc_state_t;

    localparam int unsigned TX_MIN_FRAME = 60;
    localparam int unsigned TX_MAX_FRAME = 1514;

endpackage

// File: rtl/tx_sat_adder.sv
// CNT_W-bit saturating adder: clamps to all-ones on carry-out and flags it.
module tx_sat_adder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic [CNT_W-1:0] a,
    input  logic [CNT_W-1:0] b,
    output logic [CNT_W-1:0] sum_c,
    output logic             ovf_c
);

    logic [CNT_W:0] full_c;

    always_comb begin
        full_c = {1'b0, a} + {1'b0, b};
        ovf_c  = full_c[CNT_W];
        sum_c  = full_c[CNT_W] ? '1 : full_c[CNT_W-1:0];
    end

endmodule

// File: rtl/tx_frame_byte_counter.sv
// Per-frame TX byte counter: accumulates valid bytes per beat and, at end of
// frame, latches the length together with pad / oversize / saturation status.
module tx_frame_byte_counter
    import tx_engine_pkg::*;
#(
    parameter  int unsigned DATA_BYTES = 8,
    parameter  int unsigned CNT_W      = 16,
    parameter  int unsigned MIN_FRAME  = TX_MIN_FRAME,
    parameter  int unsigned MAX_FRAME  = TX_MAX_FRAME,
    localparam int unsigned EB_W       = $clog2(DATA_BYTES)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             DATA_VALID,
    input  logic             SOF,
    input  logic             EOF,
    input  logic [EB_W-1:0]  EOF_BYTES,
    output logic [CNT_W-1:0] BYTE_COUNTER,
    output logic [CNT_W-1:0] FRAME_LEN,
    output logic [CNT_W-1:0] PAD_BYTES,
    output logic             FRAME_DONE,
    output logic             PAD_REQ,
    output logic             OVERSIZE,
    output logic             SATURATED,
    output logic             PROTO_ERR
);

    txc_state_t       state;
    logic [CNT_W-1:0] inc_c;
    logic [CNT_W-1:0] base_c;
    logic [CNT_W-1:0] sum_c;
    logic             ovf_c;
    logic             start_c;
    logic             accept_c;
    logic             complete_c;
    logic             sat_next_c;
    logic             pad_req_c;

    // A SOF beat restarts the count from zero, so the adder base is forced low.
    always_comb begin
        start_c    = DATA_VALID & SOF;
        accept_c   = start_c | (DATA_VALID & (state == TXC_COUNT));
        complete_c = accept_c & EOF;
        inc_c      = (EOF && (EOF_BYTES != '0)) ? CNT_W'(EOF_BYTES) : CNT_W'(DATA_BYTES);
        base_c     = start_c ? '0 : BYTE_COUNTER;
        sat_next_c = ovf_c | (~start_c & SATURATED);
        pad_req_c  = 32'(sum_c) < MIN_FRAME;
    end

    tx_sat_adder #(
        .CNT_W (CNT_W)
    ) u_sat_adder (
        .a     (base_c),
        .b     (inc_c),
        .sum_c (sum_c),
        .ovf_c (ovf_c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= TXC_IDLE;
            BYTE_COUNTER <= '0;
            FRAME_LEN    <= '0;
            PAD_BYTES    <= '0;
            FRAME_DONE   <= 1'b0;
            PAD_REQ      <= 1'b0;
            OVERSIZE     <= 1'b0;
            SATURATED    <= 1'b0;
            PROTO_ERR    <= 1'b0;
        end else if (CLR) begin
            state        <= TXC_IDLE;
            BYTE_COUNTER <= '0;
            FRAME_LEN    <= '0;
            PAD_BYTES    <= '0;
            FRAME_DONE   <= 1'b0;
            PAD_REQ      <= 1'b0;
            OVERSIZE     <= 1'b0;
            SATURATED    <= 1'b0;
            PROTO_ERR    <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            // SOF while counting drops the old frame; a non-SOF beat in IDLE is stray.
            PROTO_ERR  <= DATA_VALID & (SOF ? (state == TXC_COUNT) : (state == TXC_IDLE));

            if (accept_c) begin
                BYTE_COUNTER <= sum_c;
                SATURATED    <= sat_next_c;
                state        <= EOF ? TXC_IDLE : TXC_COUNT;
            end

            if (complete_c) begin
                FRAME_LEN  <= sum_c;
                PAD_REQ    <= pad_req_c;
                PAD_BYTES  <= pad_req_c ? (CNT_W'(MIN_FRAME) - sum_c) : '0;
                OVERSIZE   <= (32'(sum_c) > MAX_FRAME) | sat_next_c;
                FRAME_DONE <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_byte_counter.sv
// Randomized + directed bench for tx_frame_byte_counter at CNT_W=16 and CNT_W=8,
// checked against a frame-level reference model using unbounded byte totals.
module tb_tx_frame_byte_counter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CLR;
    logic        DATA_VALID;
    logic        SOF;
    logic        EOF;
    logic [2:0]  EOF_BYTES;

    logic [15:0] bc16, fl16, pb16;
    logic        fd16, pr16, ov16, sa16, pe16;
    logic [7:0]  bc8, fl8, pb8;
    logic        fd8, pr8, ov8, sa8, pe8;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int total      = 0;
    int last_total = 0;
    bit in_frame   = 0;
    bit done_seen  = 0;
    bit exp_done   = 0;
    bit exp_perr   = 0;

    always #5 CLK = ~CLK;

    tx_frame_byte_counter #(.DATA_BYTES(8), .CNT_W(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .DATA_VALID(DATA_VALID), .SOF(SOF), .EOF(EOF),
        .EOF_BYTES(EOF_BYTES), .BYTE_COUNTER(bc16), .FRAME_LEN(fl16), .PAD_BYTES(pb16),
        .FRAME_DONE(fd16), .PAD_REQ(pr16), .OVERSIZE(ov16), .SATURATED(sa16), .PROTO_ERR(pe16)
    );

    tx_frame_byte_counter #(.DATA_BYTES(8), .CNT_W(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .DATA_VALID(DATA_VALID), .SOF(SOF), .EOF(EOF),
        .EOF_BYTES(EOF_BYTES), .BYTE_COUNTER(bc8), .FRAME_LEN(fl8), .PAD_BYTES(pb8),
        .FRAME_DONE(fd8), .PAD_REQ(pr8), .OVERSIZE(ov8), .SATURATED(sa8), .PROTO_ERR(pe8)
    );

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        total     = 0;
        last_total = 0;
        in_frame  = 0;
        done_seen = 0;
        exp_done  = 0;
        exp_perr  = 0;
    endtask

    task automatic model_beat(input bit dv, input bit sof, input bit eof, input int eb, input bit clr);
        int inc;
        exp_done = 0;
        exp_perr = 0;
        if (clr) begin
            model_reset();
        end else if (dv) begin
            inc = (eof && eb != 0) ? eb : 8;
            if (sof) begin
                exp_perr = in_frame;
                total    = inc;
                in_frame = 1;
            end else if (in_frame) begin
                total += inc;
            end else begin
                exp_perr = 1;
            end
            if (in_frame && eof) begin
                last_total = total;
                done_seen  = 1;
                exp_done   = 1;
                in_frame   = 0;
            end
        end
    endtask

    // Expected outputs derived from unbounded totals and the counter's ceiling
    task automatic check_dut(input string pfx, input int mx,
                             input int bc, input int fl, input int pb,
                             input bit fd, input bit pr, input bit ov, input bit sa, input bit pe);
        int cnt, len, pad;
        bit preq, over;
        cnt  = (total > mx) ? mx : total;
        len  = 0; preq = 0; pad = 0; over = 0;
        if (done_seen) begin
            len  = (last_total > mx) ? mx : last_total;
            preq = len < 60;
            pad  = preq ? 60 - len : 0;
            over = (last_total > 1514) || (last_total > mx);
        end
        check({pfx, "_byte_counter"}, bc, cnt);
        check({pfx, "_frame_len"},    fl, len);
        check({pfx, "_pad_bytes"},    pb, pad);
        check({pfx, "_frame_done"},   fd, exp_done);
        check({pfx, "_pad_req"},      pr, preq);
        check({pfx, "_oversize"},     ov, over);
        check({pfx, "_saturated"},    sa, total > mx);
        check({pfx, "_proto_err"},    pe, exp_perr);
    endtask

    task automatic compare_all();
        check_dut("w16", 65535, int'(bc16), int'(fl16), int'(pb16), fd16, pr16, ov16, sa16, pe16);
        check_dut("w8",  255,   int'(bc8),  int'(fl8),  int'(pb8),  fd8,  pr8,  ov8,  sa8,  pe8);
    endtask

    task automatic step(input bit dv, input bit sof, input bit eof, input int eb, input bit clr);
        DATA_VALID = dv;
        SOF        = sof;
        EOF        = eof;
        EOF_BYTES  = 3'(eb);
        CLR        = clr;
        @(posedge CLK);
        model_beat(dv, sof, eof, eb, clr);
        #1;
        compare_all();
        DATA_VALID = 1'b0;
        SOF        = 1'b0;
        EOF        = 1'b0;
        CLR        = 1'b0;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Full-beat frame of n beats; last beat carries EOF with eb
    task automatic frame(input int n, input int eb);
        for (int i = 0; i < n; i++)
            step(1, i == 0, i == n - 1, (i == n - 1) ? eb : 0, 0);
    endtask

    task automatic async_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge CLK);
        #1;
        compare_all();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; CLR = 1'b0; DATA_VALID = 1'b0; SOF = 1'b0; EOF = 1'b0; EOF_BYTES = '0;
        @(posedge CLK);
        #1;
        compare_all();
        RESET = 1'b0;
        bubble(2);

        // 8 beats: 7*8 + 4 = 60, no padding
        frame(8, 4);
        check("t1_len", fl16, 60);
        check("t1_pad_req", pr16, 0);
        bubble(1);

        // Short frame with bubbles: 8 + 2 = 10, pad 50
        step(1, 1, 0, 0, 0);
        bubble(3);
        step(1, 0, 1, 2, 0);
        check("t2_pad_bytes", pb16, 50);
        bubble(2);

        // 190 full beats: 1520, oversize
        frame(190, 0);
        check("t3_len", fl16, 1520);
        check("t3_oversize", ov16, 1);

        // 40 full beats saturate the 8-bit counter, next SOF clears SATURATED
        frame(40, 0);
        check("t4_cnt8", bc8, 255);
        check("t4_sat8", sa8, 1);
        check("t4_ovs8", ov8, 1);
        step(1, 1, 0, 0, 0);
        check("t4_sat8_clr", sa8, 0);
        step(1, 0, 1, 5, 0);

        // Single-beat frame, then a stray beat in IDLE
        step(1, 1, 1, 0, 0);
        check("t5_pad_bytes", pb16, 52);
        step(1, 0, 1, 3, 0);
        check("t5_proto_err", pe16, 1);

        // SOF mid-frame drops the old frame
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("t6_proto_err", pe16, 1);
        step(1, 0, 1, 1, 0);

        // Async reset mid-frame, then a fresh frame counts from 0
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        async_reset();
        frame(3, 6);
        check("t6_len_after_reset", fl16, 22);

        // Synchronous clear mid-frame
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
